// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD command engine.
package sd_pkg;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  localparam int FRAME_BITS = 48;
  localparam int R1_BITS    = 8;
  localparam int R37_BITS   = 40;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  // Fixed CRC7 values; CMD0/CMD8 are the only commands a card checks in SPI mode.
  localparam logic [6:0] CRC7_CMD0    = 7'h4A;
  localparam logic [6:0] CRC7_CMD8    = 7'h43;
  localparam logic [6:0] CRC7_DEFAULT = 7'h7F;

  function automatic logic is_long_resp(input logic [5:0] idx);
    return (idx == CMD8) || (idx == CMD58);
  endfunction

  function automatic logic [6:0] fixed_crc7(input logic [5:0] idx);
    case (idx)
      CMD0:                 return CRC7_CMD0;
      CMD8:                 return CRC7_CMD8;
      CMD41, CMD55, CMD58:  return CRC7_DEFAULT;
      default:              return CRC7_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7 + x^3 + 1, init 0) over a 40-bit command header, MSB first.
module sd_crc7 (
  input  logic [39:0] i_data,
  output logic [6:0]  o_crc
);

  always_comb begin
    o_crc = '0;
    for (int i = 39; i >= 0; i--) begin
      o_crc = {o_crc[5:0], 1'b0} ^ ({7{i_data[i] ^ o_crc[6]}} & 7'h09);
    end
  end

endmodule

// File: rtl/sd_cmd_resp.sv
// SPI-mode SD command engine: sends a 48-bit frame on DI, then hunts and captures the
// R1 / R3 / R7 response on DO. Define SD_CMD_CRC7_EN to compute CRC7 instead of fixed bytes.
module sd_cmd_resp
  import sd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  index,
  input  logic [31:0] argument,
  input  logic        isStart,
  output logic        isBusy,
  output logic        isFinish,
  output logic        DI,
  input  logic        DO,
  output logic [39:0] response
);

  localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);
  localparam int CNT_W = $clog2(FRAME_BITS);

  state_t                r_state;
  state_t                w_state_next;
  logic [FRAME_BITS-2:0] r_frame;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [TO_W-1:0]       r_wait_cnt;
  logic                  r_long;
  logic [R37_BITS-1:0]   r_rx;
  logic                  r_di;
  logic [R37_BITS-1:0]   r_response;

  logic [39:0]           w_header;
  logic [6:0]            w_crc7;
  logic [FRAME_BITS-1:0] w_frame;
  logic [CNT_W-1:0]      w_rx_len;
  logic [R37_BITS-1:0]   w_rx_next;
  logic                  w_rx_last;
  logic                  w_timeout;

  assign w_header = {2'b01, index, argument};

`ifdef SD_CMD_CRC7_EN
  sd_crc7 u_crc7 (
    .i_data (w_header),
    .o_crc  (w_crc7)
  );
`else
  assign w_crc7 = fixed_crc7(index);
`endif

  assign w_frame   = {w_header, w_crc7, 1'b1};
  assign w_rx_len  = r_long ? CNT_W'(R37_BITS) : CNT_W'(R1_BITS);
  assign w_rx_next = {r_rx[R37_BITS-2:0], DO};
  // r_bit_cnt holds bits already captured, so this is the final bit arriving now.
  assign w_rx_last = (r_bit_cnt == w_rx_len - 1'b1);
  assign w_timeout = (r_wait_cnt == TO_W'(RESP_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_state_next = r_state;
    isBusy       = (r_state != IDLE);
    isFinish     = 1'b0;
    case (r_state)
      IDLE: if (isStart) w_state_next = SEND;
      SEND: if (r_bit_cnt == '0) w_state_next = WAIT;
      WAIT: begin
        if (!DO)            w_state_next = RECV;
        else if (w_timeout) w_state_next = DONE;
      end
      RECV: if (w_rx_last) w_state_next = DONE;
      DONE: begin
        isFinish = 1'b1;
        if (!isStart) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame    <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_long     <= 1'b0;
      r_rx       <= '0;
      r_di       <= 1'b1;
      r_response <= '1;
    end else begin
      case (r_state)
        IDLE: begin
          r_di <= 1'b1;
          if (isStart) begin
            r_di      <= w_frame[FRAME_BITS-1];
            r_frame   <= w_frame[FRAME_BITS-2:0];
            r_long    <= is_long_resp(index);
            r_bit_cnt <= CNT_W'(FRAME_BITS - 1);
          end
        end
        SEND: begin
          if (r_bit_cnt == '0) begin
            r_di       <= 1'b1;
            r_wait_cnt <= '0;
          end else begin
            r_di      <= r_frame[FRAME_BITS-2];
            r_frame   <= {r_frame[FRAME_BITS-3:0], 1'b1};
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        WAIT: begin
          if (!DO) begin
            r_rx      <= w_rx_next;
            r_bit_cnt <= CNT_W'(1);
          end else if (w_timeout) begin
            r_response <= '1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        RECV: begin
          r_rx      <= w_rx_next;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_rx_last)
            r_response <= r_long ? w_rx_next : {32'h0, w_rx_next[R1_BITS-1:0]};
        end
        default: ;
      endcase
    end
  end

  assign DI       = r_di;
  assign response = r_response;

endmodule

// File: tb/tb_sd_cmd_resp.sv
// Self-checking bench for sd_cmd_resp (default build, fixed CRC bytes) with a card-side model.
module tb_sd_cmd_resp;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  index;
  logic [31:0] argument;
  logic        isStart;
  logic        isBusy;
  logic        isFinish;
  logic        DI;
  logic        DO;
  logic [39:0] response;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [39:0] exp_resp = '1;

  sd_cmd_resp #(.RESP_TIMEOUT(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .index    (index),
    .argument (argument),
    .isStart  (isStart),
    .isBusy   (isBusy),
    .isFinish (isFinish),
    .DI       (DI),
    .DO       (DO),
    .response (response)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic logic model_long(input logic [5:0] idx);
    return (idx == 6'd8) || (idx == 6'd58);
  endfunction

  // Card-visible frame: start+transmission bits, index, argument, CRC7, end bit.
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [6:0] crc;
    crc = (idx == 6'd0) ? 7'h4A : (idx == 6'd8) ? 7'h43 : 7'h7F;
    return {2'b01, idx, arg, crc, 1'b1};
  endfunction

  // Level on DO that the DUT samples at posedge p (p counted from the accepting edge, p=0).
  function automatic logic card_do(input int p, input int delay, input int len,
                                   input logic [39:0] bits);
    int k;
    if (delay == 0) return 1'b1;
    k = p - (48 + delay);
    if (k < 0 || k >= len) return 1'b1;
    return bits[len-1-k];
  endfunction

  // delay: first response bit is sampled on edge 48+delay; 0 means the card never answers.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int delay,
                         input logic [7:0] r1, input logic [31:0] pay, input int hold);
    logic [47:0] frame;
    logic [39:0] bits;
    logic [39:0] prev;
    int          len;
    int          fin_edge;
    int          exp_edge;
    logic        di_low;
    logic        fin_low;

    prev = exp_resp;
    len  = model_long(idx) ? 40 : 8;
    bits = model_long(idx) ? {r1, pay} : {32'h0, r1};
    if (delay == 0 || delay > T) begin
      exp_resp = '1;
      exp_edge = 48 + T;
    end else begin
      exp_resp = bits;
      exp_edge = 47 + delay + len;
    end

    index    = idx;
    argument = arg;
    isStart  = 1'b1;
    DO       = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      frame[47-i] = DI;
      if (i == 0) begin
        check("busy_in_send", isBusy, 1'b1);
        check("resp_kept_on_start", response, prev);
        index    = 6'($urandom);
        argument = $urandom;
      end
    end
    check("di_frame", frame, model_frame(idx, arg));

    DO = card_do(48, delay, len, bits);
    fin_edge = -1;
    for (int c = 48; c < 48 + T + 80; c++) begin
      @(negedge clk);
      if (isFinish) begin
        fin_edge = c;
        break;
      end
      DO = card_do(c + 1, delay, len, bits);
    end
    DO = 1'b1;
    check("finish_edge", 64'(fin_edge), 64'(exp_edge));
    check("response", response, exp_resp);
    check("busy_in_done", isBusy, 1'b1);

    di_low  = 1'b0;
    fin_low = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      di_low  = di_low | ~DI;
      fin_low = fin_low | ~isFinish;
    end
    check("no_retrigger_di", di_low, 1'b0);
    check("finish_held", fin_low, 1'b0);
    check("response_held", response, exp_resp);

    isStart = 1'b0;
    @(negedge clk);
    check("finish_drop", isFinish, 1'b0);
    check("busy_drop", isBusy, 1'b0);
  endtask

  initial begin
    logic [5:0]  ridx;
    int          rdelay;

    reset    = 1'b1;
    isStart  = 1'b0;
    DO       = 1'b1;
    index    = '0;
    argument = '0;
    repeat (3) @(negedge clk);
    check("rst_di", DI, 1'b1);
    check("rst_busy", isBusy, 1'b0);
    check("rst_finish", isFinish, 1'b0);
    check("rst_response", response, 40'hFF_FFFF_FFFF);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(6'd0,  32'h0,     16, 8'h01, 32'h0,         5);
    run_cmd(6'd8,  32'h1AA,   5,  8'h01, 32'h0000_01AA, 3);
    run_cmd(6'd58, 32'h0,     3,  8'h00, 32'hC0FF_8000, 2);
    check("ocr_ccs_bit", response[30], 1'b1);
    run_cmd(6'd55, 32'h0,     0,  8'h00, 32'h0,         100);
    run_cmd(6'd41, $urandom,  T,  {1'b0, 7'($urandom)}, $urandom, 1);
    run_cmd(6'd55, $urandom,  1,  {1'b0, 7'($urandom)}, $urandom, 2);

    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 5))
        0:       ridx = 6'd0;
        1:       ridx = 6'd8;
        2:       ridx = 6'd55;
        3:       ridx = 6'd41;
        4:       ridx = 6'd58;
        default: ridx = 6'($urandom);
      endcase
      rdelay = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, T));
      run_cmd(ridx, $urandom, rdelay, {1'b0, 7'($urandom)}, $urandom,
              int'($urandom_range(1, 4)));
    end

    // Abort mid-frame while frame bit 20 is on DI.
    index    = 6'd41;
    argument = 32'h4000_0000;
    isStart  = 1'b1;
    @(posedge clk);
    repeat (28) @(negedge clk);
    reset   = 1'b1;
    isStart = 1'b0;
    @(negedge clk);
    check("abort_di", DI, 1'b1);
    check("abort_busy", isBusy, 1'b0);
    check("abort_finish", isFinish, 1'b0);
    check("abort_response", response, 40'hFF_FFFF_FFFF);
    reset    = 1'b0;
    exp_resp = '1;
    @(negedge clk);
    run_cmd(6'd41, 32'h4000_0000, 2, 8'h00, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
